doorlock_ctrl: RTL and testbench

- Parametrised keypad door-lock controller; successor to the fixed 32-digit/4-bit doorlock top.
- Owns digit entry buffer, registered-password store, short/long star decode, compare, fail counter with lockout timer, and password-change mode.
- Sits between keypad/display logic (digit source) and actuator/indicator logic (unlock, locked, limit).
- Digits arrive pre-mapped, with any shuffling already applied upstream.

---
 rtl/doorlock_pkg.sv | 24 ++
 rtl/doorlock_star_decode.sv | 29 ++
 rtl/doorlock_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_doorlock_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/doorlock_pkg.sv
// Shared types and helpers for the keypad door-lock controller.
package doorlock_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_LOCKOUT, S_SET
  } state_t;

  localparam int MIN_PW_LEN = 4;
  // Widest code the compare helper handles; callers zero-extend to this.
  localparam int CMP_MAX_W  = 512;

  // Codes match when lengths agree and the low len*digit_w bits agree.
  function automatic logic pw_match(input logic [CMP_MAX_W-1:0] a,
                                    input logic [CMP_MAX_W-1:0] b,
                                    input int len_a, input int len_b,
                                    input int digit_w);
    logic [CMP_MAX_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < CMP_MAX_W; i++)
      if (i < len_a * digit_w) mask[i] = 1'b1;
    return (len_a == len_b) && (((a ^ b) & mask) == '0);
  endfunction

endpackage

// File: rtl/doorlock_star_decode.sv
// Star key hold counter: short pulse on early release, long pulse once at LONG_CYC.
module doorlock_star_decode #(
  parameter int LONG_CYC = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic star,
  output logic short_confirm,
  output logic long_confirm
);
  localparam int CW = $clog2(LONG_CYC + 1);

  logic [CW-1:0] cnt;

  // Counter parks at LONG_CYC, so the long pulse fires once and the release is silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      short_confirm <= 1'b0;
      long_confirm  <= 1'b0;
    end else begin
      short_confirm <= !star && (cnt != '0) && (cnt < CW'(LONG_CYC));
      long_confirm  <= star && (cnt == CW'(LONG_CYC - 1));
      if (!star)                     cnt <= '0;
      else if (cnt < CW'(LONG_CYC))  cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/doorlock_ctrl.sv
// Keypad door-lock controller: entry buffer, password store, compare, lockout, set mode.
// Optional master-code override enabled by DOORLOCK_MASTER_OVERRIDE_EN.
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int DIGIT_W  = 4,
  parameter int PW_LEN   = 8,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 1000,
  parameter int LONG_CYC = 300,
  parameter int OPEN_CYC = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          digit_valid,
  input  logic [DIGIT_W-1:0]            digit,
  input  logic                          star,
  input  logic                          clear,
  input  logic [PW_LEN*DIGIT_W-1:0]     master_pw,
  input  logic [$clog2(PW_LEN+1)-1:0]   master_len,
  output logic                          unlock,
  output logic                          same,
  output logic                          master_same,
  output logic                          limit,
  output logic                          long_confirm,
  output logic                          pw_set,
  output logic                          set_mode,
  output logic [$clog2(PW_LEN+1)-1:0]   entry_len
);
  localparam int BW   = PW_LEN * DIGIT_W;
  localparam int LW   = $clog2(PW_LEN + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (LOCK_CYC > OPEN_CYC) ? LOCK_CYC : OPEN_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state;
  logic [BW-1:0] entry_buf, buf_nx, pw_reg;
  logic [LW-1:0] len_nx, pw_len;
  logic [FW-1:0] fail_cnt;
  logic [TW-1:0] timer;
  logic          match_q, m_pw, short_p, long_p;

  doorlock_star_decode #(.LONG_CYC(LONG_CYC)) u_star (
    .clk(clk), .rst_n(rst_n), .star(star),
    .short_confirm(short_p), .long_confirm(long_p)
  );
  assign long_confirm = long_p;

  // Next buffer state; star decisions look at this so a same-cycle digit counts.
  always_comb begin
    buf_nx = entry_buf;
    len_nx = entry_len;
    if (clear) begin
      buf_nx = '0;
      len_nx = '0;
    end else if (digit_valid && entry_len < LW'(PW_LEN)) begin
      buf_nx = {entry_buf[BW-DIGIT_W-1:0], digit};
      len_nx = entry_len + 1'b1;
    end
  end

  assign m_pw = pw_set && pw_match(CMP_MAX_W'(buf_nx), CMP_MAX_W'(pw_reg),
                                   int'(len_nx), int'(pw_len), DIGIT_W);

`ifdef DOORLOCK_MASTER_OVERRIDE_EN
  logic m_master;
  assign m_master = pw_match(CMP_MAX_W'(buf_nx), CMP_MAX_W'(master_pw),
                             int'(len_nx), int'(master_len), DIGIT_W);
`else
  logic unused_master;
  assign unused_master = ^{master_pw, master_len};
  assign master_same   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      entry_buf <= '0;
      entry_len <= '0;
      pw_reg    <= '0;
      pw_len    <= '0;
      pw_set    <= 1'b0;
      fail_cnt  <= '0;
      timer     <= '0;
      match_q   <= 1'b0;
      unlock    <= 1'b0;
      limit     <= 1'b0;
      same      <= 1'b0;
      set_mode  <= 1'b0;
`ifdef DOORLOCK_MASTER_OVERRIDE_EN
      master_same <= 1'b0;
`endif
    end else begin
      same <= 1'b0;
`ifdef DOORLOCK_MASTER_OVERRIDE_EN
      master_same <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          entry_buf <= buf_nx;
          entry_len <= len_nx;
          if (digit_valid && !clear) state <= S_ENTRY;
        end

        S_ENTRY: begin
          entry_buf <= buf_nx;
          entry_len <= len_nx;
          if (short_p) begin
`ifdef DOORLOCK_MASTER_OVERRIDE_EN
            if (m_master) begin
              master_same <= 1'b1;
              fail_cnt    <= '0;
              entry_len   <= '0;
              unlock      <= 1'b1;
              timer       <= TW'(OPEN_CYC - 1);
              state       <= S_OPEN;
            end else
`endif
            if (!pw_set && len_nx >= LW'(MIN_PW_LEN)) begin
              pw_reg    <= buf_nx;
              pw_len    <= len_nx;
              pw_set    <= 1'b1;
              entry_len <= '0;
              state     <= S_IDLE;
            end else begin
              match_q <= m_pw;
              same    <= m_pw;
              state   <= S_CHECK;
            end
          end else if (long_p) begin
            if (m_pw) begin
              set_mode  <= 1'b1;
              entry_len <= '0;
              state     <= S_SET;
            end else begin
              match_q <= 1'b0;
              state   <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          entry_len <= '0;
          if (match_q) begin
            fail_cnt <= '0;
            unlock   <= 1'b1;
            timer    <= TW'(OPEN_CYC - 1);
            state    <= S_OPEN;
          end else if (fail_cnt == FW'(MAX_FAIL - 1)) begin
            fail_cnt <= '0;
            limit    <= 1'b1;
            timer    <= TW'(LOCK_CYC - 1);
            state    <= S_LOCKOUT;
          end else begin
            fail_cnt <= fail_cnt + 1'b1;
            state    <= S_IDLE;
          end
        end

        S_OPEN: begin
          if (timer == '0) begin
            unlock <= 1'b0;
            state  <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_LOCKOUT: begin
`ifdef DOORLOCK_MASTER_OVERRIDE_EN
          entry_buf <= buf_nx;
          entry_len <= len_nx;
          if (short_p && m_master) begin
            limit       <= 1'b0;
            master_same <= 1'b1;
            fail_cnt    <= '0;
            entry_len   <= '0;
            unlock      <= 1'b1;
            timer       <= TW'(OPEN_CYC - 1);
            state       <= S_OPEN;
          end else
`endif
          if (timer == '0) begin
            limit     <= 1'b0;
            entry_len <= '0;
            state     <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_SET: begin
          entry_buf <= buf_nx;
          entry_len <= len_nx;
          if (clear) begin
            set_mode <= 1'b0;
            state    <= S_IDLE;
          end else if (short_p) begin
            entry_len <= '0;
            if (len_nx >= LW'(MIN_PW_LEN)) begin
              pw_reg   <= buf_nx;
              pw_len   <= len_nx;
              set_mode <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Scoreboard bench for doorlock_ctrl; master-override cases run with DOORLOCK_MASTER_OVERRIDE_EN.
module tb_doorlock_ctrl;
  localparam int DW = 4, PL = 8, LW = $clog2(PL + 1);
  localparam int EV_NONE = 0, EV_SAME = 1, EV_MASTER = 2, EV_LONG = 3, EV_OPEN = 4, EV_LOCK = 5;

  typedef struct { int code; int dur; } ev_t;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              digit_valid = 1'b0, star = 1'b0, clear = 1'b0;
  logic [DW-1:0]     digit = '0;
  logic [PL*DW-1:0]  master_pw = '0;
  logic [LW-1:0]     master_len = LW'(4);
  logic              unlock, same, master_same, limit, long_confirm, pw_set, set_mode;
  logic [LW-1:0]     entry_len;

  int  n_run = 0, n_fail = 0;
  int  open_run = 0, lock_run = 0;
  ev_t exp_q[$];

  doorlock_ctrl #(.DIGIT_W(DW), .PW_LEN(PL), .MAX_FAIL(3), .LOCK_CYC(20),
                  .LONG_CYC(10), .OPEN_CYC(5)) dut (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
    .star(star), .clear(clear), .master_pw(master_pw), .master_len(master_len),
    .unlock(unlock), .same(same), .master_same(master_same), .limit(limit),
    .long_confirm(long_confirm), .pw_set(pw_set), .set_mode(set_mode),
    .entry_len(entry_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input int code, input int dur);
    exp_q.push_back('{code, dur});
  endtask

  task automatic got_ev(input int code, input int dur);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected", code, EV_NONE);
    end else begin
      e = exp_q.pop_front();
      chk("sb_code", code, e.code);
      if (e.dur >= 0) chk("sb_dur", dur, e.dur);
    end
  endtask

  // Output monitor: pulses become events, unlock/limit windows become timed events.
  always @(negedge clk) begin
    if (!rst_n) begin
      open_run = 0;
      lock_run = 0;
    end else begin
      if (limit) lock_run++;
      else if (lock_run != 0) begin got_ev(EV_LOCK, lock_run); lock_run = 0; end
      if (unlock) open_run++;
      else if (open_run != 0) begin got_ev(EV_OPEN, open_run); open_run = 0; end
      if (long_confirm) got_ev(EV_LONG, 1);
      if (same)         got_ev(EV_SAME, 1);
      if (master_same)  got_ev(EV_MASTER, 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter(input logic [63:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      digit_valid = 1'b1;
      digit = code[(n-1-i)*4 +: 4];
      @(negedge clk);
      digit_valid = 1'b0;
    end
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    star = 1'b1;
    cyc(hold);
    star = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_unlock", int'(unlock), 0);
    chk("rst_limit", int'(limit), 0);
    chk("rst_pw_set", int'(pw_set), 0);
    chk("rst_set_mode", int'(set_mode), 0);
    chk("rst_entry_len", int'(entry_len), 0);
    rst_n = 1'b1;
    cyc(2);

    // first use registers 1234
    enter(64'h1234, 4);
    chk("first_len", int'(entry_len), 4);
    press(2); cyc(8);
    chk("first_pw_set", int'(pw_set), 1);
    chk("first_unlock", int'(unlock), 0);
    chk("first_len_clr", int'(entry_len), 0);

    // correct code opens for 5 cycles
    expect_ev(EV_SAME, 1); expect_ev(EV_OPEN, 5);
    enter(64'h1234, 4); press(2); cyc(12);

    // three mismatches -> lockout
    enter(64'h9999, 4); press(2); cyc(6);
    enter(64'h9999, 4); press(2); cyc(6);
    chk("pre_lock_limit", int'(limit), 0);
    expect_ev(EV_LOCK, 20);
    enter(64'h9999, 4); press(2); cyc(4);
    chk("lock_limit", int'(limit), 1);
`ifndef DOORLOCK_MASTER_OVERRIDE_EN
    enter(64'h55, 2);
    chk("lock_ignore_len", int'(entry_len), 0);
`endif
    cyc(25);
    chk("post_lock_limit", int'(limit), 0);
    expect_ev(EV_SAME, 1); expect_ev(EV_OPEN, 5);
    enter(64'h1234, 4); press(2); cyc(12);

    // long press enters set mode, new code 56780
    expect_ev(EV_LONG, 1);
    enter(64'h1234, 4); press(12); cyc(3);
    chk("set_mode_on", int'(set_mode), 1);
    chk("set_len_clr", int'(entry_len), 0);
    enter(64'h56780, 5); press(2); cyc(6);
    chk("set_mode_off", int'(set_mode), 0);
    enter(64'h1234, 4); press(2); cyc(8);
    chk("old_pw_unlock", int'(unlock), 0);
    expect_ev(EV_SAME, 1); expect_ev(EV_OPEN, 5);
    enter(64'h56780, 5); press(2); cyc(12);

    // saturation and clear priority
    enter(64'h123456789, 9);
    chk("len_sat", int'(entry_len), 8);
    @(negedge clk);
    digit_valid = 1'b1; clear = 1'b1; digit = 4'h7;
    @(negedge clk);
    digit_valid = 1'b0; clear = 1'b0;
    chk("clear_prio", int'(entry_len), 0);
    enter(64'h12, 2);
    rst_n = 1'b0;
    #1;
    chk("async_pw_set", int'(pw_set), 0);
    chk("async_len", int'(entry_len), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

`ifdef DOORLOCK_MASTER_OVERRIDE_EN
    // master 0000 ends a lockout
    enter(64'h1234, 4); press(2); cyc(8);
    chk("m_pw_set", int'(pw_set), 1);
    enter(64'h9999, 4); press(2); cyc(6);
    enter(64'h9999, 4); press(2); cyc(6);
    expect_ev(EV_LOCK, -1); expect_ev(EV_MASTER, 1); expect_ev(EV_OPEN, 5);
    enter(64'h9999, 4); press(2); cyc(4);
    chk("m_lock_limit", int'(limit), 1);
    enter(64'h0000, 4); press(2); cyc(12);
    chk("m_limit_drop", int'(limit), 0);
`endif

    cyc(5);
    chk("sb_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
